// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the CPU-side mul/div sequencer and the iterative
// multiply/divide unit: start/op/operands out, done strobe and result back.
interface muldiv_ctrl_if;
    logic        unit_start;
    logic [1:0]  unit_op;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        unit_done;
    logic [31:0] unit_hi;
    logic [31:0] unit_lo;

    modport master (
        output unit_start,
        output unit_op,
        output unit_a,
        output unit_b,
        input  unit_done,
        input  unit_hi,
        input  unit_lo
    );

    modport slave (
        input  unit_start,
        input  unit_op,
        input  unit_a,
        input  unit_b,
        output unit_done,
        output unit_hi,
        output unit_lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// MUL/MULTU/DIV/DIVU sequencer and HI/LO register owner: stalls fetch while the
// external iterative unit runs, then commits to HI/LO or to the GPR for MUL.
module muldiv_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_mul,
    input  logic                 op_multu,
    input  logic                 op_div,
    input  logic                 op_divu,
    input  logic                 op_mthi,
    input  logic                 op_mtlo,
    input  logic                 op_mfhi,
    input  logic                 op_mflo,
    input  logic [31:0]          rs_data,
    input  logic [31:0]          rt_data,
    muldiv_ctrl_if.master        unit,
    output logic                 stall,
    output logic                 gpr_we,
    output logic [31:0]          gpr_wdata,
    output logic [31:0]          hi,
    output logic [31:0]          lo,
    output logic [31:0]          mf_data,
    output logic                 div_zero,
    output logic                 timeout_err
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] run_cnt;
    logic             start_req;
    logic [1:0]       sel_op;
    logic             dz_hit;
    logic             launch;
    logic             zero_div;
    logic             done_ok;
    logic             done_to;

    // When several decode flags collide, the divide forms win over multiplies.
    always_comb begin
        sel_op = OP_MUL;
        if (op_div) begin
            sel_op = OP_DIV;
        end else if (op_divu) begin
            sel_op = OP_DIVU;
        end else if (op_multu) begin
            sel_op = OP_MULTU;
        end
        start_req = op_mul | op_multu | op_div | op_divu;
        dz_hit    = (op_div | op_divu) && (rt_data == 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        zero_div   = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    if (dz_hit) begin
                        zero_div   = 1'b1;
                        state_next = WB;
                    end else begin
                        launch     = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // A done on the final allowed cycle still counts as success.
                if (unit.unit_done) begin
                    done_ok    = 1'b1;
                    state_next = WB;
                end else if (run_cnt == CNT_LAST) begin
                    done_to    = 1'b1;
                    state_next = WB;
                end
            end
            WB: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall = rst_n && (((state == IDLE) && start_req) || (state == RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit.unit_start <= 1'b0;
            unit.unit_op    <= OP_MUL;
            unit.unit_a     <= 32'd0;
            unit.unit_b     <= 32'd0;
            run_cnt         <= '0;
            hi              <= 32'd0;
            lo              <= 32'd0;
            gpr_we          <= 1'b0;
            gpr_wdata       <= 32'd0;
            div_zero        <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            unit.unit_start <= launch;
            gpr_we          <= done_ok && (unit.unit_op == OP_MUL);
            div_zero        <= zero_div;
            timeout_err     <= done_to;

            if (launch) begin
                unit.unit_op <= sel_op;
                unit.unit_a  <= rs_data;
                unit.unit_b  <= rt_data;
                run_cnt      <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end

            if (done_ok) begin
                if (unit.unit_op == OP_MUL) begin
                    gpr_wdata <= unit.unit_lo;
                end else begin
                    hi <= unit.unit_hi;
                    lo <= unit.unit_lo;
                end
            end

            if (state == IDLE) begin
                if (op_mthi) begin
                    hi <= rs_data;
                end
                if (op_mtlo) begin
                    lo <= rs_data;
                end
            end
        end
    end

    always_comb begin
        mf_data = 32'd0;
        if (op_mfhi) begin
            mf_data = hi;
        end else if (op_mflo) begin
            mf_data = lo;
        end
    end

endmodule
